// File: rtl/dbg_abscmd_seq_pkg.sv
// Shared debug-module types for the abstract-command sequencer.
// State encoding, cmderr codes, regno ranges and the command layout.
package debug_types;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_REQ,
    S_DONE
  } abscmd_state_t;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
  localparam logic [2:0] CMDERR_BUS        = 3'd5;
  localparam logic [2:0] CMDERR_OTHER      = 3'd7;

  localparam logic [7:0] CMDTYPE_ACC_REG = 8'd0;
  localparam logic [7:0] CMDTYPE_QUICK   = 8'd1;
  localparam logic [7:0] CMDTYPE_ACC_MEM = 8'd2;

  localparam logic [2:0] AARSIZE_32 = 3'd2;

  localparam logic [15:0] REGNO_GPR_BASE  = 16'h1000;
  localparam logic [15:0] REGNO_GPR_LAST  = 16'h101F;
  localparam logic [15:0] REGNO_CSR_LIMIT = 16'h0FFF;

  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        rsvd;
    logic [2:0]  aarsize;
    logic        postinc;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } acc_reg_t;

  function automatic logic is_gpr(input logic [15:0] r);
    return (r >= REGNO_GPR_BASE) && (r <= REGNO_GPR_LAST);
  endfunction

  function automatic logic is_csr(input logic [15:0] r);
    return r <= REGNO_CSR_LIMIT;
  endfunction

endpackage

// File: rtl/dbg_abscmd_seq_if.sv
// Hart debug access port: GPR and CSR request/ack channels.
// master = sequencer side, slave = hart side.
interface dbg_abscmd_seq_if;

  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        rf_write_en;
  logic        rf_read_en;
  logic        rf_write_ack;
  logic        rf_read_ack;
  logic [31:0] rf_rdata;

  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_write_en;
  logic        csr_read_en;
  logic        csr_write_ack;
  logic        csr_read_ack;
  logic [31:0] csr_rdata;

  modport master (
    output rf_addr, rf_wdata, rf_write_en, rf_read_en,
    input  rf_write_ack, rf_read_ack, rf_rdata,
    output csr_addr, csr_wdata, csr_write_en, csr_read_en,
    input  csr_write_ack, csr_read_ack, csr_rdata
  );

  modport slave (
    input  rf_addr, rf_wdata, rf_write_en, rf_read_en,
    output rf_write_ack, rf_read_ack, rf_rdata,
    input  csr_addr, csr_wdata, csr_write_en, csr_read_en,
    output csr_write_ack, csr_read_ack, csr_rdata
  );

endinterface

// File: rtl/dbg_ack_timer.sv
// Ack watchdog: counts cycles while enabled, flags the last one.
// Cleared whenever the sequencer is outside its request phase.
module dbg_ack_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign expired_o = en_i && (cnt_q == LAST);

  // advance while waiting, saturate on expiry
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !expired_o) cnt_d = cnt_q + 16'd1;
  end

  // counter register with sync reset/clear
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dbg_abscmd_seq.sv
// Access Register abstract-command sequencer for the debug module.
// Define DBG_CSR_ACCESS_EN to enable the CSR access path.
module dbg_abscmd_seq
  import debug_types::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iDmActive,
  input  logic        iHalted,
  input  logic        iCmdValid,
  input  logic [31:0] iCmd,
  input  logic [31:0] iData0,
  output logic        oBusy,
  output logic        oCmderrValid,
  output logic [2:0]  oCmderr,
  output logic        oData0Wr,
  output logic [31:0] oData0,
  output logic        oRegnoWr,
  output logic [15:0] oRegno,
  dbg_abscmd_seq_if.master acc
);

  abscmd_state_t state_q, state_d;
  acc_reg_t      cmd_q;
  logic [31:0]   wdata_q, rdata_q;
  logic [2:0]    err_q, dec_err;
  logic          pend_q, dec_go;
  logic          srst, tmo, sel_gpr, gpr_ack, csr_ack, hit_ack;
  logic          in_req, in_done, done_err, done_ok, busy_hit;
  logic [31:0]   csr_rd, hit_rdata;

  assign srst    = iRst || !iDmActive;
  assign in_req  = state_q == S_REQ;
  assign in_done = state_q == S_DONE;
  assign sel_gpr = is_gpr(cmd_q.regno);

  dbg_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (iClk),
    .rst_i     (srst),
    .clr_i     (!in_req),
    .en_i      (in_req),
    .expired_o (tmo)
  );

  assign gpr_ack = cmd_q.write ? acc.rf_write_ack : acc.rf_read_ack;

`ifdef DBG_CSR_ACCESS_EN
  assign csr_ack = cmd_q.write ? acc.csr_write_ack : acc.csr_read_ack;
  assign csr_rd  = acc.csr_rdata;
`else
  assign csr_ack = 1'b0;
  assign csr_rd  = '0;
  logic unused_csr;
  assign unused_csr = ^{acc.csr_write_ack, acc.csr_read_ack,
                        acc.csr_rdata};
`endif

  assign hit_ack   = sel_gpr ? gpr_ack : csr_ack;
  assign hit_rdata = sel_gpr ? acc.rf_rdata : csr_rd;

  logic unused_cmd;
  assign unused_cmd = cmd_q.rsvd;

  // decode and validate the latched command, first match wins
  always_comb begin
    dec_err = CMDERR_NONE;
    dec_go  = 1'b0;
    if (cmd_q.cmdtype != CMDTYPE_ACC_REG)  dec_err = CMDERR_NOTSUP;
    else if (cmd_q.aarsize != AARSIZE_32)  dec_err = CMDERR_NOTSUP;
    else if (cmd_q.postexec)               dec_err = CMDERR_NOTSUP;
    else if (!cmd_q.transfer)              dec_err = CMDERR_NONE;
    else if (!iHalted)                     dec_err = CMDERR_HALTRESUME;
    else if (is_gpr(cmd_q.regno))          dec_go  = 1'b1;
    else if (is_csr(cmd_q.regno)) begin
`ifdef DBG_CSR_ACCESS_EN
      dec_go  = 1'b1;
`else
      dec_err = CMDERR_NOTSUP;
`endif
    end
    else                                   dec_err = CMDERR_EXCEPTION;
  end

  // state register
  always_ff @(posedge iClk) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (iCmdValid) state_d = S_DECODE;
      S_DECODE: state_d = dec_go ? S_REQ : S_DONE;
      S_REQ:    if (hit_ack || tmo) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // command latch, result capture and deferred busy error
  always_ff @(posedge iClk) begin
    if (srst) begin
      cmd_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= CMDERR_NONE;
      pend_q  <= 1'b0;
    end else begin
      pend_q <= busy_hit && done_err;
      if (state_q == S_IDLE && iCmdValid) begin
        cmd_q   <= acc_reg_t'(iCmd);
        wdata_q <= iData0;
        err_q   <= CMDERR_NONE;
      end
      if (state_q == S_DECODE) err_q <= dec_err;
      if (in_req && hit_ack)   rdata_q <= hit_rdata;
      else if (in_req && tmo)  err_q <= CMDERR_BUS;
    end
  end

  // DM-side outputs and access port drive
  always_comb begin
    oBusy        = state_q != S_IDLE;
    busy_hit     = iCmdValid && oBusy;
    done_err     = in_done && (err_q != CMDERR_NONE);
    done_ok      = in_done && (err_q == CMDERR_NONE) && cmd_q.transfer;
    oCmderrValid = done_err || busy_hit || pend_q;
    oCmderr      = CMDERR_NONE;
    if (done_err)                oCmderr = err_q;
    else if (busy_hit || pend_q) oCmderr = CMDERR_BUSY;
    oData0Wr = done_ok && !cmd_q.write;
    oData0   = oData0Wr ? rdata_q : '0;
    oRegnoWr = done_ok && cmd_q.postinc;
    oRegno   = oRegnoWr ? cmd_q.regno + 16'd1 : '0;
  end

  assign acc.rf_read_en  = in_req && sel_gpr && !cmd_q.write;
  assign acc.rf_write_en = in_req && sel_gpr && cmd_q.write;
  assign acc.rf_addr     = (in_req && sel_gpr) ? cmd_q.regno[4:0] : '0;
  assign acc.rf_wdata    = acc.rf_write_en ? wdata_q : '0;

`ifdef DBG_CSR_ACCESS_EN
  assign acc.csr_read_en  = in_req && !sel_gpr && !cmd_q.write;
  assign acc.csr_write_en = in_req && !sel_gpr && cmd_q.write;
  assign acc.csr_addr     = (in_req && !sel_gpr) ? cmd_q.regno[11:0] : '0;
  assign acc.csr_wdata    = acc.csr_write_en ? wdata_q : '0;
`else
  assign acc.csr_read_en  = 1'b0;
  assign acc.csr_write_en = 1'b0;
  assign acc.csr_addr     = '0;
  assign acc.csr_wdata    = '0;
`endif

endmodule

// File: tb/tb_dbg_abscmd_seq.sv
// Scoreboard bench for dbg_abscmd_seq (TIMEOUT=8).
// Expected pulses are queued with their cycle; a monitor pops them.
module tb_dbg_abscmd_seq;

  logic        iClk = 1'b0;
  logic        iRst, iDmActive, iHalted, iCmdValid;
  logic [31:0] iCmd, iData0;
  logic        oBusy, oCmderrValid, oData0Wr, oRegnoWr;
  logic [2:0]  oCmderr;
  logic [31:0] oData0;
  logic [15:0] oRegno;

  dbg_abscmd_seq_if acc ();

  dbg_abscmd_seq #(.TIMEOUT(8)) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iDmActive    (iDmActive),
    .iHalted      (iHalted),
    .iCmdValid    (iCmdValid),
    .iCmd         (iCmd),
    .iData0       (iData0),
    .oBusy        (oBusy),
    .oCmderrValid (oCmderrValid),
    .oCmderr      (oCmderr),
    .oData0Wr     (oData0Wr),
    .oData0       (oData0),
    .oRegnoWr     (oRegnoWr),
    .oRegno       (oRegno),
    .acc          (acc)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   en_cnt = 0;
  int   c0 = 0;
  int   e0 = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int c, int k, logic [31:0] v);
    exp_t e;
    e.c = c; e.kind = k; e.val = v;
    q.push_back(e);
  endtask

  task automatic check_pulse(int k, logic [31:0] v);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected pulse: kind %0d val %h cyc %0d",
               k, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val !== v || e.c != cyc) begin
        errors++;
        $display("FAIL pulse: got kind %0d val %h cyc %0d, want kind %0d val %h cyc %0d",
                 k, v, cyc, e.kind, e.val, e.c);
      end
    end
  endtask

  // monitor: kinds 0=cmderr, 1=data0, 2=regno
  always @(negedge iClk) begin
    if (oCmderrValid) check_pulse(0, {29'd0, oCmderr});
    if (oData0Wr)     check_pulse(1, oData0);
    if (oRegnoWr)     check_pulse(2, {16'd0, oRegno});
    if (acc.rf_read_en || acc.rf_write_en ||
        acc.csr_read_en || acc.csr_write_en) en_cnt++;
  end

  task automatic at(int n);
    while (cyc < n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic smp(int n);
    at(n);
    @(negedge iClk);
  endtask

  task automatic issue(logic [31:0] cmd, logic [31:0] d);
    iCmd = cmd; iData0 = d; iCmdValid = 1'b1; c0 = cyc;
    @(posedge iClk);
    #1;
    iCmdValid = 1'b0;
  endtask

  logic [31:0] err_cmds [5];
  logic [2:0]  err_codes [5];

  initial begin
    err_cmds[0] = 32'h0032_1000; err_codes[0] = 3'd2;
    err_cmds[1] = 32'h0022_C000; err_codes[1] = 3'd3;
    err_cmds[2] = 32'h0100_0000; err_codes[2] = 3'd2;
    err_cmds[3] = 32'h003B_1001; err_codes[3] = 3'd2;
    err_cmds[4] = 32'h0026_1005; err_codes[4] = 3'd2;

    iRst = 1'b1; iDmActive = 1'b1; iHalted = 1'b0; iCmdValid = 1'b0;
    iCmd = '0; iData0 = '0;
    acc.rf_write_ack = 1'b0; acc.rf_read_ack = 1'b0; acc.rf_rdata = '0;
    acc.csr_write_ack = 1'b0; acc.csr_read_ack = 1'b0; acc.csr_rdata = '0;

    smp(2);
    chk("rst_busy", {31'd0, oBusy}, 0);
    chk("rst_pulses", {29'd0, oCmderrValid, oData0Wr, oRegnoWr}, 0);
    chk("rst_cmderr", {29'd0, oCmderr}, 0);
    chk("rst_vals", oData0 | {16'd0, oRegno}, 0);
    chk("rst_en", {28'd0, acc.rf_read_en, acc.rf_write_en,
                   acc.csr_read_en, acc.csr_write_en}, 0);
    chk("rst_addr", {15'd0, acc.rf_addr, acc.csr_addr}, 0);
    chk("rst_wdata", acc.rf_wdata | acc.csr_wdata, 0);
    at(3); iRst = 1'b0;

    // read x5, ack in 4th REQ cycle
    at(5); iHalted = 1'b1;
    issue(32'h0022_1005, 32'h0);
    push(c0 + 6, 1, 32'hDEAD_BEEF);
    smp(c0 + 2);
    chk("rd_en", {31'd0, acc.rf_read_en}, 1);
    chk("rd_wren", {31'd0, acc.rf_write_en}, 0);
    chk("rd_addr", {27'd0, acc.rf_addr}, 5);
    chk("rd_busy_dec", {31'd0, oBusy}, 1);
    at(c0 + 5); acc.rf_read_ack = 1'b1; acc.rf_rdata = 32'hDEAD_BEEF;
    at(c0 + 6); acc.rf_read_ack = 1'b0; acc.rf_rdata = '0;
    smp(c0 + 6);
    chk("rd_en_drop", {31'd0, acc.rf_read_en}, 0);
    chk("rd_busy_done", {31'd0, oBusy}, 1);
    smp(c0 + 7);
    chk("rd_busy_idle", {31'd0, oBusy}, 0);

    // write x1 with postincrement, wrong-type ack first
    issue(32'h002B_1001, 32'h0000_1234);
    push(c0 + 4, 2, 32'h0000_1002);
    smp(c0 + 2);
    chk("wr_en", {31'd0, acc.rf_write_en}, 1);
    chk("wr_rden", {31'd0, acc.rf_read_en}, 0);
    chk("wr_addr", {27'd0, acc.rf_addr}, 1);
    chk("wr_wdata", acc.rf_wdata, 32'h0000_1234);
    acc.rf_read_ack = 1'b1;
    at(c0 + 3); acc.rf_read_ack = 1'b0; acc.rf_write_ack = 1'b1;
    smp(c0 + 3);
    chk("wr_en_hold", {31'd0, acc.rf_write_en}, 1);
    at(c0 + 4); acc.rf_write_ack = 1'b0;

    // back-to-back in first IDLE cycle: not halted
    at(c0 + 5);
    iHalted = 1'b0;
    e0 = en_cnt;
    issue(32'h0022_1005, 32'h0);
    push(c0 + 2, 0, 32'd4);
    smp(c0 + 3);
    chk("nohalt_busy", {31'd0, oBusy}, 0);
    chk("nohalt_en", en_cnt - e0, 0);

    // decode errors
    iHalted = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(err_cmds[i], 32'h0);
      push(c0 + 2, 0, {29'd0, err_codes[i]});
      smp(c0 + 3);
      chk("err_idle", {31'd0, oBusy}, 0);
    end

    // transfer=0 with collision in DONE (no DONE error)
    issue(32'h0020_0000, 32'h0);
    at(c0 + 2);
    push(c0 + 2, 0, 32'd1);
    iCmd = 32'h0022_1005; iCmdValid = 1'b1;
    smp(c0 + 2);
    chk("nx_busy_done", {31'd0, oBusy}, 1);
    at(c0 + 3); iCmdValid = 1'b0;
    smp(c0 + 3);
    chk("nx_ignored", {31'd0, oBusy}, 0);

    // collision with DONE error: busy deferred one cycle
    issue(32'h0100_0000, 32'h0);
    at(c0 + 2);
    push(c0 + 2, 0, 32'd2);
    push(c0 + 3, 0, 32'd1);
    iCmd = 32'h0022_1005; iCmdValid = 1'b1;
    at(c0 + 3); iCmdValid = 1'b0;
    smp(c0 + 3);
    chk("defer_busy", {31'd0, oBusy}, 0);

    // timeout with a busy collision during REQ
    issue(32'h0022_1003, 32'h0);
    push(c0 + 4, 0, 32'd1);
    push(c0 + 10, 0, 32'd5);
    at(c0 + 4); iCmd = 32'h0022_1007; iCmdValid = 1'b1;
    at(c0 + 5); iCmdValid = 1'b0;
    smp(c0 + 6);
    chk("to_addr", {27'd0, acc.rf_addr}, 3);
    smp(c0 + 9);
    chk("to_en_last", {31'd0, acc.rf_read_en}, 1);
    smp(c0 + 10);
    chk("to_en_off", {31'd0, acc.rf_read_en}, 0);
    chk("to_busy_done", {31'd0, oBusy}, 1);
    smp(c0 + 11);
    chk("to_idle", {31'd0, oBusy}, 0);

    // reset, then dmactive=0, in REQ; late ack ignored
    for (int r = 0; r < 2; r++) begin
      issue(32'h0022_1007, 32'h0);
      at(c0 + 3);
      if (r == 0) iRst = 1'b1;
      else        iDmActive = 1'b0;
      at(c0 + 4);
      iRst = 1'b0; iDmActive = 1'b1;
      acc.rf_read_ack = 1'b1; acc.rf_rdata = 32'h5555_AAAA;
      smp(c0 + 4);
      chk("ra_busy", {31'd0, oBusy}, 0);
      chk("ra_en", {31'd0, acc.rf_read_en}, 0);
      chk("ra_addr", {27'd0, acc.rf_addr}, 0);
      at(c0 + 6); acc.rf_read_ack = 1'b0; acc.rf_rdata = '0;
      smp(c0 + 7);
      chk("ra_quiet", {31'd0, oBusy}, 0);
    end

    // CSR read of regno 0x300
    issue(32'h0022_0300, 32'h0);
`ifdef DBG_CSR_ACCESS_EN
    push(c0 + 3, 1, 32'hCAFE_F00D);
    smp(c0 + 2);
    chk("csr_en", {31'd0, acc.csr_read_en}, 1);
    chk("csr_addr", {20'd0, acc.csr_addr}, 32'h300);
    acc.csr_read_ack = 1'b1; acc.csr_rdata = 32'hCAFE_F00D;
    at(c0 + 3); acc.csr_read_ack = 1'b0; acc.csr_rdata = '0;
`else
    push(c0 + 2, 0, 32'd2);
    smp(c0 + 2);
    chk("csr_en", {31'd0, acc.csr_read_en}, 0);
    chk("csr_addr", {20'd0, acc.csr_addr}, 0);
`endif
    smp(c0 + 4);
    chk("csr_idle", {31'd0, oBusy}, 0);

    smp(cyc + 3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
